// File: rtl/audio_pcm_wb_if.sv
// Wishbone register-port bundle for the audio PCM playback block.
interface audio_pcm_wb_if;
   logic [1:0]  wb_addr;
   logic [31:0] wb_rdata;
   logic [31:0] wb_wdata;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_ack;

   modport master (
      output wb_addr, wb_wdata, wb_we, wb_cyc,
      input  wb_rdata, wb_ack
   );

   modport slave (
      input  wb_addr, wb_wdata, wb_we, wb_cyc,
      output wb_rdata, wb_ack
   );
endinterface

// File: rtl/audio_pcm_wb.sv
// Stereo PCM playback: Wishbone-fed sample FIFO, rate divider, two 1st-order sigma-delta DACs, USB SOF pop counter.
// Define AUDIO_UNDERRUN_CNT_EN to add the saturating underrun counter at CSR[31:16].
module audio_pcm_wb #(
   parameter int FIFO_AW   = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   audio_pcm_wb_if.slave   wb,
   input  logic            usb_sof,
   output logic [1:0]      audio
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic                 ack_q;
   logic                 req_we;
   logic [1:0]           req_addr;
   logic [31:0]          req_wdata;
   logic                 req_seen;
   logic                 wr_stb;
   logic                 csr_wr;
   logic                 div_wr;
   logic                 data_wr;
   logic                 flush;

   logic                 run;
   logic                 overflow;
   logic [DIV_WIDTH-1:0] div_reg;
   logic [DIV_WIDTH-1:0] div_cnt;
   logic                 tick;

   logic [31:0]          mem [DEPTH];
   logic [FIFO_AW:0]     wr_ptr;
   logic [FIFO_AW:0]     rd_ptr;
   logic [FIFO_AW:0]     level;
   logic                 empty;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 ovf_set;

   logic [15:0]          smp_l;
   logic [15:0]          smp_r;
   logic [16:0]          acc_l;
   logic [16:0]          acc_r;

   logic [15:0]          pop_cnt;
   logic [15:0]          sofcnt;
   logic [15:0]          urun_cnt;
   logic [31:0]          rd_mux;

   // Request fields are captured when the cycle is first seen so side effects
   // in the ack cycle do not depend on the master still holding them.
   assign req_seen = wb.wb_cyc && !ack_q;
   assign wr_stb   = ack_q && req_we;
   assign csr_wr   = wr_stb && (req_addr == 2'd0);
   assign div_wr   = wr_stb && (req_addr == 2'd1);
   assign data_wr  = wr_stb && (req_addr == 2'd2);
   assign flush    = csr_wr && req_wdata[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         ack_q     <= 1'b0;
         req_we    <= 1'b0;
         req_addr  <= 2'd0;
         req_wdata <= 32'd0;
      end else begin
         ack_q <= req_seen;
         if (req_seen) begin
            req_we    <= wb.wb_we;
            req_addr  <= wb.wb_addr;
            req_wdata <= wb.wb_wdata;
         end
      end
   end

   assign wb.wb_ack = ack_q;

   // Level is at most DEPTH, so its MSB alone marks full.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = level[FIFO_AW];
   assign tick    = run && (div_cnt == '0);
   assign pop     = tick && !empty && !flush;
   assign push    = data_wr && (!full || pop) && !flush;
   assign ovf_set = data_wr && full && !pop && !flush;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= req_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         run      <= 1'b0;
         overflow <= 1'b0;
         div_reg  <= DIV_WIDTH'(499);
         div_cnt  <= DIV_WIDTH'(499);
      end else begin
         if (csr_wr) run <= req_wdata[0];
         if (csr_wr && req_wdata[3]) overflow <= 1'b0;
         else if (ovf_set)           overflow <= 1'b1;
         if (div_wr) div_reg <= req_wdata[DIV_WIDTH-1:0];
         if (div_wr)                div_cnt <= req_wdata[DIV_WIDTH-1:0];
         else if (!run || tick)     div_cnt <= div_reg;
         else                       div_cnt <= div_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || !run) begin
         smp_l <= 16'd0;
         smp_r <= 16'd0;
      end else if (tick) begin
         smp_l <= pop ? mem[rd_ptr[FIFO_AW-1:0]][15:0]  : 16'd0;
         smp_r <= pop ? mem[rd_ptr[FIFO_AW-1:0]][31:16] : 16'd0;
      end
   end

   // Offset-binary input makes signed 0 land at half-scale density.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_l <= 17'd0;
         acc_r <= 17'd0;
         audio <= 2'b00;
      end else begin
         acc_l <= {1'b0, acc_l[15:0]} + {1'b0, smp_l ^ 16'h8000};
         acc_r <= {1'b0, acc_r[15:0]} + {1'b0, smp_r ^ 16'h8000};
         audio <= {acc_r[16], acc_l[16]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pop_cnt <= 16'd0;
         sofcnt  <= 16'd0;
      end else if (usb_sof) begin
         sofcnt  <= pop_cnt;
         pop_cnt <= pop ? 16'd1 : 16'd0;
      end else if (pop && (pop_cnt != 16'hFFFF)) begin
         pop_cnt <= pop_cnt + 16'd1;
      end
   end

`ifdef AUDIO_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst)                                   urun_cnt <= 16'd0;
      else if (csr_wr && req_wdata[3])            urun_cnt <= 16'd0;
      else if (tick && empty && urun_cnt != 16'hFFFF) urun_cnt <= urun_cnt + 16'd1;
   end
`else
   always_comb urun_cnt = 16'd0;
`endif

   always_comb begin
      rd_mux = 32'd0;
      case (wb.wb_addr)
         2'd0: rd_mux = {urun_cnt, 12'(level), overflow, full, empty, run};
         2'd1: rd_mux = 32'(div_reg);
         2'd3: rd_mux = {16'd0, sofcnt};
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst)                         wb.wb_rdata <= 32'd0;
      else if (req_seen && !wb.wb_we)   wb.wb_rdata <= rd_mux;
      else                              wb.wb_rdata <= 32'd0;
   end

endmodule

// File: tb/tb_audio_pcm_wb.sv
// Directed self-checking bench for audio_pcm_wb: registers, FIFO limits, playback density, SOF feedback, underruns.
module tb_audio_pcm_wb;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       usb_sof = 1'b0;
   logic [1:0] audio;
   int         n_chk = 0;
   int         n_fail = 0;

   audio_pcm_wb_if bus ();

   audio_pcm_wb #(.FIFO_AW(8), .DIV_WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .wb      (bus.slave),
      .usb_sof (usb_sof),
      .audio   (audio)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_ack(output logic [31:0] data);
      bit seen = 1'b0;
      data = 32'hDEAD_BEEF;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (bus.wb_ack) begin
            seen = 1'b1;
            data = bus.wb_rdata;
         end
      end
      if (!seen) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      @(negedge clk);
      bus.wb_cyc = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_wdata = d;
      wait_ack(dummy);
      @(negedge clk);
      bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.wb_cyc = 1'b1; bus.wb_we = 1'b0; bus.wb_addr = a;
      wait_ack(d);
      @(negedge clk);
      bus.wb_cyc = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp_urun;
      int          hi_l, hi_r, n_win;

      bus.wb_cyc = 1'b0; bus.wb_we = 1'b0; bus.wb_addr = 2'd0; bus.wb_wdata = 32'd0;

      // reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_audio", {30'd0, audio}, 32'd0);
      chk("rst_ack", {31'd0, bus.wb_ack}, 32'd0);
      chk("rst_rdata", bus.wb_rdata, 32'd0);
      rst = 1'b1;
      wb_read(2'd0, rd); chk("rst_csr", rd, 32'h0000_0002);
      wb_read(2'd1, rd); chk("rst_div", rd, 32'd499);
      wb_read(2'd3, rd); chk("rst_sofcnt", rd, 32'd0);
      wb_read(2'd2, rd); chk("data_reads_0", rd, 32'd0);

      // fill then flush
      for (int i = 0; i < 5; i++) wb_write(2'd2, 32'h0001_0002);
      wb_read(2'd0, rd); chk("fill_level5", rd, 32'h0000_0050);
      wb_write(2'd0, 32'h2);
      wb_read(2'd0, rd); chk("flush_empty", rd, 32'h0000_0002);

      // divider upper bits are not stored
      wb_write(2'd1, 32'hABCD_0009);
      wb_read(2'd1, rd); chk("div_upper0", rd, 32'h0000_0009);

      // playback: left 0x8000 -> density 0, right 0x7FFF -> ~100%
      for (int i = 0; i < 4; i++) wb_write(2'd2, 32'h7FFF_8000);
      wb_write(2'd0, 32'h1);
      hi_l = 0; hi_r = 0; n_win = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k >= 15 && k <= 48) begin
            n_win++;
            hi_l += int'(audio[0]);
            hi_r += int'(audio[1]);
         end
      end
      chk("drain_left_zero", 32'(hi_l), 32'd0);
      chk("drain_right_high", 32'(hi_r >= n_win - 1), 32'd1);
      hi_l = 0; hi_r = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         hi_l += int'(audio[0]);
         hi_r += int'(audio[1]);
      end
      chk("idle_left_half", 32'(hi_l), 32'd10);
      chk("idle_right_half", 32'(hi_r), 32'd10);
      wb_read(2'd0, rd); chk("drained_csr", {16'd0, rd[15:0]}, 32'h0000_0003);
      wb_write(2'd0, 32'h0);

      // overflow at full depth
      for (int i = 0; i < 257; i++) wb_write(2'd2, i);
      wb_read(2'd0, rd); chk("ovf_full", rd, 32'h0000_100C);
      wb_write(2'd0, 32'h8);
      wb_read(2'd0, rd); chk("ovf_clear", rd, 32'h0000_1004);
      wb_write(2'd0, 32'h2);

      // SOF feedback: 24000 clk frame at DIV=499 -> 48 pops
      wb_write(2'd1, 32'd499);
      for (int i = 0; i < 200; i++) wb_write(2'd2, 32'h0100_0100);
      wb_write(2'd0, 32'h1);
      @(negedge clk); usb_sof = 1'b1;
      @(negedge clk); usb_sof = 1'b0;
      repeat (23999) @(negedge clk);
      usb_sof = 1'b1;
      @(negedge clk); usb_sof = 1'b0;
      wb_read(2'd3, rd); chk("sofcnt_48", rd, 32'd48);
      wb_write(2'd0, 32'h2);

      // underruns with an empty FIFO, ~100 clk at DIV=9
      wb_write(2'd1, 32'd9);
      wb_write(2'd0, 32'h9);
      repeat (105) @(negedge clk);
`ifdef AUDIO_UNDERRUN_CNT_EN
      exp_urun = 32'h000A_0003;
`else
      exp_urun = 32'h0000_0003;
`endif
      wb_read(2'd0, rd); chk("underrun_cnt", rd, exp_urun);
      wb_write(2'd0, 32'h2);

      // reset mid-transfer drops ack and FIFO contents
      for (int i = 0; i < 3; i++) wb_write(2'd2, 32'h1234_5678);
      @(negedge clk);
      bus.wb_cyc = 1'b1; bus.wb_we = 1'b0; bus.wb_addr = 2'd0;
      @(negedge clk);
      chk("mid_ack_before", {31'd0, bus.wb_ack}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_ack_dropped", {31'd0, bus.wb_ack}, 32'd0);
      bus.wb_cyc = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      wb_read(2'd0, rd); chk("mid_fifo_empty", rd, 32'h0000_0002);
      wb_read(2'd1, rd); chk("mid_div_reset", rd, 32'd499);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_pcm_wb.md
Name: audio_pcm_wb

Overview:
- Wishbone-attached stereo audio playback block.
- CPU pushes packed 16-bit stereo PCM samples into an internal FIFO. A programmable rate divider pops one sample per tick, and two first-order sigma-delta modulators produce 1-bit outputs on the audio pads.
- Counts samples consumed per USB frame, so firmware can compute isochronous rate feedback.

Parameters:
- FIFO_AW, 8, log2 of FIFO depth in stereo words (depth 256); legal range 2..11.
- DIV_WIDTH, 16, width of the sample-rate divider register.

Ports:
- clk  in  1  system clock (24 MHz nominal).
- rst  in  1  synchronous active-low reset: low on a clk edge resets all state.
- audio  out  2  sigma-delta bitstreams; [0]=left, [1]=right.
- wb_addr  in  2  register address.
- wb_rdata  out  32  read data; valid only while wb_ack=1, otherwise 0.
- wb_wdata  in  32  write data.
- wb_we  in  1  write enable.
- wb_cyc  in  1  cycle/select.
- wb_ack  out  1  one-cycle acknowledge.
- usb_sof  in  1  one-clk pulse per USB start-of-frame, synchronous to clk.

Behaviour:
- Bus handshake:
  - wb_ack asserts the cycle after wb_cyc is seen while ack is low, and stays high for exactly 1 cycle.
  - Each access takes 2 cycles.
  - Write side effects occur once, in the ack cycle.
  - wb_rdata is registered and driven alongside ack.
- Registers:
  - addr0 CSR.
    - Write: bit0 = run; bit1 = flush (self-clearing, empties the FIFO); bit3 = 1 clears the overflow flag.
    - Read: bit0 run; bit1 empty; bit2 full; bit3 overflow (sticky); [15:4] FIFO level, zero-extended (0..2^FIFO_AW); [31:16] underrun count (see Optional Feature).
  - addr1 DIV (R/W).
    - Rate divider in the low DIV_WIDTH bits; upper bits read 0.
    - Tick period = DIV+1 clk cycles.
    - Reset value 499 (48 kHz at 24 MHz).
  - addr2 DATA (write only; reads 0).
    - [15:0] left, [31:16] right, both signed two's complement.
    - A write pushes the word into the FIFO.
  - addr3 SOFCNT (read only): [15:0] number of samples popped between the last two usb_sof pulses; upper bits read 0.
- FIFO full/write rules:
  - Full is evaluated before the cycle.
  - A DATA write when full with no simultaneous pop is dropped and sets overflow.
  - A write while full with a pop in the same cycle is accepted; the level stays at max.
  - Flush has priority over a simultaneous push or pop; the level becomes 0.
- Divider:
  - The counter counts down to 0, then reloads DIV and emits a 1-cycle tick.
  - A DIV write reloads the counter immediately.
  - The divider runs only while run=1; run=0 holds the counter at DIV.
- On each tick:
  - FIFO non-empty: pop the word and load it into the current-sample register.
  - FIFO empty: load 0 (midscale) and count an underrun.
  - When run=0, the current sample is forced to 0.
- Sigma-delta, per channel:
  - u = sample XOR 0x8000 (offset binary).
  - 17-bit accumulator: acc <= {1'b0, acc[15:0]} + u each clk.
  - audio bit = acc[16], registered.
  - Sample 0 gives 50% density; 0x7FFF gives about 100%; 0x8000 gives a constant 0.
- SOF counting:
  - The pop counter increments on each tick that pops.
  - On usb_sof, SOFCNT <= counter, and the counter restarts at 0, or at 1 if a pop coincides.
  - The counter saturates at 0xFFFF.
- Reset values: run=0, DIV=499, FIFO empty, overflow=0, SOFCNT=0, counters 0, samples 0, accumulators 0, audio=2'b00, wb_ack=0, wb_rdata=0.
- Reset asserted mid-transfer drops the ack and all FIFO contents.

Optional Feature:
- Macro AUDIO_UNDERRUN_CNT_EN.
- Defined:
  - A 16-bit saturating underrun counter counts ticks with an empty FIFO while run=1; it reads at CSR[31:16].
  - A CSR write with bit3=1 also clears it.
- Undefined: no counter logic; CSR[31:16] reads 0.

Test Plan:
- Reset check: hold rst=0 for 4 clk, release; read CSR -> 0x00000002 (empty); read DIV -> 499; audio=00.
- FIFO fill: write DATA 0x00010002 five times with run=0; CSR read -> level 5 ([15:4]=5), empty=0. Flush by writing CSR=0x2 -> level 0, empty=1.
- Playback density: set DIV=9, push 0x7FFF8000 ×4, set run=1.
  - While the FIFO drains, audio[0] is constantly 0 and audio[1] is high ≥99% of cycles.
  - After 4 ticks (~40 clk), empty=1 and outputs settle to 50% density.
- Overflow: push 2^FIFO_AW+1 words with run=0 -> full=1, overflow=1, level=256. Write CSR=0x8 -> overflow=0, level unchanged.
- SOF feedback: DIV=499, FIFO kept non-empty, usb_sof pulses every 24000 clk -> SOFCNT reads 48 after the second pulse.
- Underrun (AUDIO_UNDERRUN_CNT_EN): run=1 with an empty FIFO and DIV=9 for 100 clk -> CSR[31:16]=10; without the macro -> 0.
